zybo_counter_ctrl_top: RTL

Parametrised board-level counter controller for Zybo Z7-20 bring-up. It synchronises and debounces the four push-buttons and synchronises the four slide switches. A rate-selectable tick divider drives an up/down counter with pause, single-step and clear controls. The counter value goes to the LEDs through a selectable display mode. It sits directly under the board wrapper and replaces the fixed-rate LED counter top.

---
 rtl/zybo_counter_ctrl_top.sv | 130 +++++++++++++
 1 files changed

// File: rtl/zybo_counter_ctrl_top.sv
`default_nettype none
// ============================================================================
// zybo_counter_ctrl_top : debounced-button, rate-selectable LED counter top
// Optional: ZYBO_CTR_SATURATE_EN (saturating counter instead of wrapping)
// Rev 1.0
// ============================================================================
module zybo_counter_ctrl_top #(
    parameter int DIV_W = 26,
    parameter int DEB_W = 20,
    parameter int CNT_W = 8,
    parameter int LED_W = 4
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [3:0]       btn,
    input  logic [3:0]       sw,
    output logic [LED_W-1:0] led,
    output logic [CNT_W-1:0] count,
    output logic             tick
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [1:0] DM_LOW  = 2'd0;
    localparam logic [1:0] DM_HIGH = 2'd1;
    localparam logic [1:0] DM_TICK = 2'd2;

    logic [3:0]       btn_s1, btn_s2, sw_s1, sw_s2;
    logic [3:0]       stable, stable_q, press;
    logic [DIV_W-1:0] div, div_mask;
    logic [0:0]       state;
    logic [1:0]       mode;
    logic             tick_tog;
    logic             step;
    logic [CNT_W-1:0] count_step;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            stable_q <= '0;
        end else begin
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            stable_q <= stable;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_deb
        logic [DEB_W-1:0] deb_cnt;
        logic             stab;

        always_ff @(posedge sysclk) begin
            if (rst) begin
                deb_cnt <= '0;
                stab    <= 1'b0;
            end else if (btn_s2[i] == stab) begin
                deb_cnt <= '0;
            end else if (&deb_cnt) begin
                stab    <= btn_s2[i];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end

        assign stable[i] = stab;
    end

    assign press = stable & ~stable_q;

    // Each rate step shortens the compared field of div by two bits.
    assign div_mask = {DIV_W{1'b1}} >> {sw_s2[3:2], 1'b0};

    always_ff @(posedge sysclk) begin
        if (rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div + 1'b1;
            tick <= ((div & div_mask) == div_mask);
        end
    end

    assign step = (state == ST_RUN) ? (tick & sw_s2[0]) : press[2];

`ifdef ZYBO_CTR_SATURATE_EN
    always_comb begin
        count_step = count;
        if (!sw_s2[1]) begin
            if (~&count) count_step = count + 1'b1;
        end else begin
            if (|count) count_step = count - 1'b1;
        end
    end
`else
    assign count_step = sw_s2[1] ? (count - 1'b1) : (count + 1'b1);
`endif

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state    <= ST_RUN;
            mode     <= DM_LOW;
            count    <= '0;
            tick_tog <= 1'b0;
            led      <= '0;
        end else begin
            // step is derived from the pre-toggle state, so a coincident toggle still counts
            if (press[1]) state <= (state == ST_RUN) ? ST_HOLD : ST_RUN;

            if (press[0])  count <= '0;
            else if (step) count <= count_step;

            tick_tog <= tick_tog ^ tick;

            if (press[3]) mode <= (mode == DM_TICK) ? DM_LOW : mode + 2'd1;

            case (mode)
                DM_LOW:  led <= count[LED_W-1:0];
                DM_HIGH: led <= count[CNT_W-1 -: LED_W];
                default: led <= {{(LED_W-1){state == ST_RUN}}, tick_tog};
            endcase
        end
    end
endmodule
`default_nettype wire
